pipe_barrel_shifter: RTL and testbench
======================================

Name: pipe_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the FP datapath (mantissa alignment and normalisation). It supports logical-right, arithmetic-right and logical-left modes and saturates on oversize shift amounts. It produces a sticky bit, the OR of every bit shifted out, for rounding. A valid/ready handshake with a pass-through tag lets add, multiply and power units share one instance with backpressure.

Parameters:
WIDTH, 24, data width in bits (>= 2)
SHW, 5, shift-amount width; pipeline depth = SHW stages
TAGW, 4, width of the opaque tag carried alongside each operand

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept operand this cycle
in_data  in  WIDTH  operand
in_amt  in  SHW  shift amount (unsigned)
in_mode  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 pass-through
in_tag  in  TAGW  tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  shifted result
out_sticky  out  1  OR of all bits discarded by the shift
out_tag  out  TAGW  tag of this result

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset, rst_n.
- Reset values: all stage valid bits are 0, and out_valid=0. out_data, out_sticky and out_tag are 0. in_ready=1 once rst_n is high.
- Pipeline structure:
  - SHW register stages. Stage k (k=0..SHW-1) applies a shift of 2^(SHW-1-k) if amount bit (SHW-1-k) is set.
  - Each stage registers data, sticky, mode, the remaining amount bits, tag and valid.
  - The last stage register drives the out_* ports.
- Latency: SHW cycles from the in_valid&&in_ready edge to out_valid with no stall (5 cycles at default).
- Throughput: 1 result per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - All stages shift together when advance=1 and hold when advance=0. The pipeline is stall-global: bubbles do not collapse.
  - Transfer occurs on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
  - out_* stay stable while out_valid&&!out_ready.
  - A bubble enters stage 0 when in_valid=0 and advance=1.
- Shift rules:
  - Logical right: zero-fill from the MSB.
  - Arithmetic right: fill with in_data[WIDTH-1].
  - Logical left: zero-fill from the LSB.
  - Pass-through: out_data=in_data and out_sticky=0, with the same latency.
- Sticky: ORs every discarded bit across all stages, for left and right shifts. It is 0 when in_amt=0.
- Saturation: when in_amt >= WIDTH (mode != 11), resolve at stage 0 by forcing the full shift:
  - logical modes give out_data=0;
  - arithmetic right gives all bits = sign;
  - out_sticky = OR of in_data, except in arithmetic mode where it is the OR of in_data[WIDTH-2:0] when sign=0 and OR of ~in_data[WIDTH-2:0]... no: it is the OR of all in_data bits not reproduced by the fill, i.e. in_data[WIDTH-2:0] for arithmetic right.
- in_amt values >= 2^SHW are impossible by width. If 2^SHW < WIDTH, saturation never triggers.
- Reset mid-operation: all in-flight operands are dropped immediately, with no output, and outputs return to their reset values.
- Simultaneous input and output transfers in the same cycle are legal and required for full throughput.

Test Plan:
- Logical right: in_data=24'h800001, amt=1, mode=00 -> after 5 cycles out_data=24'h400000, sticky=1, tag echoed.
- Arithmetic right: 24'h800000, amt=4, mode=01 -> 24'hF80000, sticky=0. Then 24'h7FFFFF, amt=23 -> 24'h000000, sticky=1.
- Logical left: 24'h000003, amt=22, mode=10 -> 24'hC00000, sticky=0. Same with amt=23 -> 24'h800000, sticky=1.
- Saturation: 24'h000010, amt=30, mode=00 -> out_data=0, sticky=1. 24'h000000, amt=31 -> 0, sticky=0.
- Backpressure: stream 8 operands with tags 0..7 while out_ready is held low from cycle 3 to cycle 10.
  - in_ready must be 0 whenever out_valid&&!out_ready.
  - Results must emerge in tag order 0..7 with no loss or duplication.
  - out_* must stay stable during the stall.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 operands in flight -> out_valid=0 immediately, no stale result after release. The first new operand appears 5 cycles after acceptance.

Source files
------------

// File: rtl/pipe_barrel_shifter_if.sv
// Handshake bundle for pipe_barrel_shifter: operand side and result side.
interface pipe_barrel_shifter_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic [TAGW-1:0]  out_tag;

  // Producer and consumer of shift requests (e.g. an FP unit or a bench)
  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_tag
  );

  // The shifter itself
  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_tag
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one power-of-two shift per stage, MSB amount bit first.
// Produces a sticky bit (OR of all discarded bits) and carries an opaque tag.
// Stall is global: every stage holds while the output is blocked.
module pipe_barrel_shifter #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipe_barrel_shifter_if.slave bus
);
  localparam logic [1:0] ModeLsr  = 2'b00;
  localparam logic [1:0] ModeAsr  = 2'b01;
  localparam logic [1:0] ModeLsl  = 2'b10;
  localparam logic [1:0] ModePass = 2'b11;
  localparam logic [WIDTH-1:0] Ones = '1;

  logic [WIDTH-1:0] data_q   [SHW];
  logic [WIDTH-1:0] data_d   [SHW];
  logic             sticky_q [SHW];
  logic             sticky_d [SHW];
  logic [1:0]       mode_q   [SHW];
  logic [1:0]       mode_d   [SHW];
  logic [SHW-1:0]   amt_q    [SHW];
  logic [SHW-1:0]   amt_d    [SHW];
  logic [TAGW-1:0]  tag_q    [SHW];
  logic [TAGW-1:0]  tag_d    [SHW];
  logic             valid_q  [SHW];
  logic             valid_d  [SHW];

  logic             advance;
  logic             saturate;
  logic [WIDTH-1:0] sat_data;
  logic             sat_sticky;
  logic [SHW-1:0]   sat_amt;

  logic [WIDTH-1:0] cur_data;
  logic             cur_sticky;
  logic [1:0]       cur_mode;
  logic [SHW-1:0]   cur_amt;
  logic [TAGW-1:0]  cur_tag;
  logic             cur_valid;
  logic [SHW-1:0]   stage_bit;
  int unsigned      sh;

  assign advance = !valid_q[SHW-1] || bus.out_ready;

  // Oversize shifts are resolved up front so the later stages see a zero amount
  always_comb begin
    saturate   = (bus.in_mode != ModePass) && (32'(bus.in_amt) >= WIDTH);
    sat_data   = bus.in_data;
    sat_sticky = 1'b0;
    sat_amt    = bus.in_amt;
    if (saturate) begin
      sat_amt = '0;
      if (bus.in_mode == ModeAsr) begin
        sat_data   = {WIDTH{bus.in_data[WIDTH-1]}};
        // The sign bit is reproduced by the fill, so only the rest is lost
        sat_sticky = |bus.in_data[WIDTH-2:0];
      end else begin
        sat_data   = '0;
        sat_sticky = |bus.in_data;
      end
    end
  end

  // Next-state for every stage: stage k consumes amount bit SHW-1-k
  always_comb begin
    cur_data   = sat_data;
    cur_sticky = sat_sticky;
    cur_mode   = bus.in_mode;
    cur_amt    = sat_amt;
    cur_tag    = bus.in_tag;
    cur_valid  = bus.in_valid;
    stage_bit  = '0;
    sh         = 0;
    for (int k = 0; k < SHW; k++) begin
      stage_bit = SHW'(1) << (SHW - 1 - k);
      sh        = 1 << (SHW - 1 - k);
      if (cur_mode != ModePass && (cur_amt & stage_bit) != '0) begin
        case (cur_mode)
          ModeLsl: begin
            cur_sticky = cur_sticky | (|(cur_data & ~(Ones >> sh)));
            cur_data   = cur_data << sh;
          end
          ModeAsr: begin
            cur_sticky = cur_sticky | (|(cur_data & ~(Ones << sh)));
            cur_data   = $unsigned($signed(cur_data) >>> sh);
          end
          default: begin
            cur_sticky = cur_sticky | (|(cur_data & ~(Ones << sh)));
            cur_data   = cur_data >> sh;
          end
        endcase
        cur_amt = cur_amt & ~stage_bit;
      end
      data_d[k]   = cur_data;
      sticky_d[k] = cur_sticky;
      mode_d[k]   = cur_mode;
      amt_d[k]    = cur_amt;
      tag_d[k]    = cur_tag;
      valid_d[k]  = cur_valid;
      if (k < SHW - 1) begin
        cur_data   = data_q[k];
        cur_sticky = sticky_q[k];
        cur_mode   = mode_q[k];
        cur_amt    = amt_q[k];
        cur_tag    = tag_q[k];
        cur_valid  = valid_q[k];
      end
    end
  end

  // Stage registers: all advance together or all hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]   <= '0;
        sticky_q[k] <= 1'b0;
        mode_q[k]   <= ModeLsr;
        amt_q[k]    <= '0;
        tag_q[k]    <= '0;
        valid_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]   <= data_d[k];
        sticky_q[k] <= sticky_d[k];
        mode_q[k]   <= mode_d[k];
        amt_q[k]    <= amt_d[k];
        tag_q[k]    <= tag_d[k];
        valid_q[k]  <= valid_d[k];
      end
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = valid_q[SHW-1];
  assign bus.out_data   = data_q[SHW-1];
  assign bus.out_sticky = sticky_q[SHW-1];
  assign bus.out_tag    = tag_q[SHW-1];
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter: driver pushes expected results,
// an independent monitor pops and compares whenever a result transfers.
module tb_pipe_barrel_shifter;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned SHW   = 5;
  localparam int unsigned TAGW  = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sticky;
    logic [TAGW-1:0]  tag;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  pipe_barrel_shifter_if #(.WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW)) bus ();

  pipe_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                      input logic [1:0] m, input logic [TAGW-1:0] t,
                      input logic [WIDTH-1:0] ed, input logic es, input bit lat);
    int   waited = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    bus.in_tag   = t;
    #4;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      #4;
      waited++;
    end
    if (!bus.in_ready) begin
      chk(1'b0, "accept_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      e.data    = ed;
      e.sticky  = es;
      e.tag     = t;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: samples 1 time unit before each rising edge
  initial begin : monitor
    bit               stalled_prev = 0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_sticky = 1'b0;
    logic [TAGW-1:0]  prev_tag = '0;
    exp_t             e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stalled_prev = 0;
      end else begin
        if (bus.out_valid && !bus.out_ready) begin
          chk(!bus.in_ready, "in_ready_during_stall", 64'(bus.in_ready), 64'd0);
          if (stalled_prev)
            chk({bus.out_data, bus.out_sticky, bus.out_tag} == {prev_data, prev_sticky, prev_tag},
                "stall_stable", 64'({bus.out_data, bus.out_sticky, bus.out_tag}),
                64'({prev_data, prev_sticky, prev_tag}));
          prev_data    = bus.out_data;
          prev_sticky  = bus.out_sticky;
          prev_tag     = bus.out_tag;
          stalled_prev = 1;
        end else begin
          stalled_prev = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_result", 64'({bus.out_data, bus.out_sticky, bus.out_tag}), 64'd0);
          end else begin
            e = sb.pop_front();
            chk({bus.out_data, bus.out_sticky, bus.out_tag} == {e.data, e.sticky, e.tag},
                "result{data,sticky,tag}", 64'({bus.out_data, bus.out_sticky, bus.out_tag}),
                64'({e.data, e.sticky, e.tag}));
            if (e.chk_lat)
              chk(cyc - e.acc_cyc == SHW, "latency", 64'(cyc - e.acc_cyc), 64'(SHW));
          end
        end
      end
    end
  end

  // Directed vectors: data, amount, mode, expected data, expected sticky
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   a;
    logic [1:0]       m;
    logic [WIDTH-1:0] ed;
    logic             es;
  } vec_t;

  vec_t vecs[12] = '{
    '{24'h800001, 5'd1,  2'b00, 24'h400000, 1'b1},
    '{24'h800000, 5'd4,  2'b01, 24'hF80000, 1'b0},
    '{24'h7FFFFF, 5'd23, 2'b01, 24'h000000, 1'b1},
    '{24'h000003, 5'd22, 2'b10, 24'hC00000, 1'b0},
    '{24'h000003, 5'd23, 2'b10, 24'h800000, 1'b1},
    '{24'h000010, 5'd30, 2'b00, 24'h000000, 1'b1},
    '{24'h000000, 5'd31, 2'b00, 24'h000000, 1'b0},
    '{24'h800001, 5'd24, 2'b01, 24'hFFFFFF, 1'b1},
    '{24'h800000, 5'd30, 2'b01, 24'hFFFFFF, 1'b0},
    '{24'h123456, 5'd5,  2'b11, 24'h123456, 1'b0},
    '{24'h80000F, 5'd0,  2'b00, 24'h80000F, 1'b0},
    '{24'h00000F, 5'd2,  2'b00, 24'h000003, 1'b1}
  };

  logic [WIDTH-1:0] bp_exp[8] = '{24'h000001, 24'h000002, 24'h000004, 24'h000008,
                                  24'h000010, 24'h000020, 24'h000040, 24'h000080};

  initial begin : main
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(bus.out_valid == 1'b0, "reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk(bus.out_data == '0, "reset_out_data", 64'(bus.out_data), 64'd0);
    chk(bus.out_sticky == 1'b0, "reset_out_sticky", 64'(bus.out_sticky), 64'd0);
    chk(bus.out_tag == '0, "reset_out_tag", 64'(bus.out_tag), 64'd0);
    chk(bus.in_ready == 1'b1, "reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Back-to-back directed vectors, no backpressure: exact latency expected
    foreach (vecs[i])
      send(vecs[i].d, vecs[i].a, vecs[i].m, TAGW'(i), vecs[i].ed, vecs[i].es, 1'b1);
    drain();

    // Stream of 8 with out_ready low for cycles 3..10 of the stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(24'h000001, SHW'(i), 2'b10, TAGW'(i), bp_exp[i], 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three operands in flight
    send(24'h0000F0, 5'd4, 2'b00, 4'hA, 24'h00000F, 1'b0, 1'b0);
    send(24'h0000F0, 5'd4, 2'b00, 4'hB, 24'h00000F, 1'b0, 1'b0);
    send(24'h0000F0, 5'd4, 2'b00, 4'hC, 24'h00000F, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk(bus.out_data == '0, "midreset_out_data", 64'(bus.out_data), 64'd0);
    chk(bus.out_tag == '0, "midreset_out_tag", 64'(bus.out_tag), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Any stale result during this window is caught by the monitor
    repeat (10) @(negedge clk);
    send(24'h000100, 5'd8, 2'b00, 4'h5, 24'h000001, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
